// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: drives a req/ack data-memory bus, stalls the pipeline
// while an access is outstanding, and returns aligned, extended load data.
module mem_access_stage #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [2:0]  funct3_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] read_data_m,
  output logic        stall_m,
  output logic        misaligned_m,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_next;
  logic [TO_W-1:0] count;
  logic [2:0]      funct3_q;
  logic [1:0]      lane_q;
  logic            access, bad, timeout;
  logic [3:0]      be_fmt;
  logic [31:0]     wdata_fmt, load_fmt, rdata_shifted;

  // Request decode: legality check, byte enables and lane-replicated store data.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    access    = valid_m & (mem_read_m | mem_write_m);
    bad       = mem_read_m & mem_write_m;
    be_fmt    = 4'b0000;
    wdata_fmt = write_data_m;
    case (funct3_m)
      3'b000, 3'b100: begin
        be_fmt    = 4'b0001 << alu_result_m[1:0];
        wdata_fmt = {4{write_data_m[7:0]}};
      end
      3'b001, 3'b101: begin
        bad       = bad | alu_result_m[0];
        be_fmt    = alu_result_m[1] ? 4'b1100 : 4'b0011;
        wdata_fmt = {2{write_data_m[15:0]}};
      end
      3'b010: begin
        bad    = bad | (alu_result_m[1:0] != 2'b00);
        be_fmt = 4'b1111;
      end
      default: bad = 1'b1;
    endcase
    if (funct3_m[2] & mem_write_m) bad = 1'b1;
  end

  assign timeout = (count == TO_W'(TIMEOUT - 1));

  // Load formatting uses the funct3 and byte lane captured when the request was issued.
  always_comb begin
    rdata_shifted = dmem_rdata >> {lane_q, 3'b000};
    case (funct3_q)
      3'b000:  load_fmt = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
      3'b100:  load_fmt = {24'd0, rdata_shifted[7:0]};
      3'b001:  load_fmt = {{16{rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b101:  load_fmt = {16'd0, rdata_shifted[15:0]};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (access & !bad) state_next = BUSY;
      BUSY:    if (dmem_ack | timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Gated by reset so nothing is stalled or flagged while the unit is held in reset.
  always_comb begin
    stall_m      = 1'b0;
    misaligned_m = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          stall_m      = access & !bad;
          misaligned_m = access & bad;
        end
        BUSY:    stall_m = 1'b1;
        default: stall_m = 1'b0;
      endcase
    end
  end

  // Bus request fields, timeout counter and load result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'd0;
      dmem_be     <= 4'd0;
      dmem_wdata  <= 32'd0;
      read_data_m <= 32'd0;
      bus_error   <= 1'b0;
      count       <= '0;
      funct3_q    <= 3'd0;
      lane_q      <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (access & !bad) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write_m;
            dmem_addr  <= {alu_result_m[31:2], 2'b00};
            dmem_be    <= be_fmt;
            dmem_wdata <= wdata_fmt;
            funct3_q   <= funct3_m;
            lane_q     <= alu_result_m[1:0];
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) read_data_m <= load_fmt;
          end else if (timeout) begin
            dmem_req  <= 1'b0;
            bus_error <= 1'b1;
            if (!dmem_we) read_data_m <= 32'd0;
          end
        end
        DONE:    count <= '0;
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, bus corner sequences,
// then randomized accesses checked against an arithmetic reference model.
module tb_mem_access_stage;

  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_m, mem_read_m, mem_write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_result_m, write_data_m;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata, read_data_m;
  logic        stall_m, misaligned_m, bus_error;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .TO_W(3)) dut (
    .clock(clock), .reset(reset),
    .valid_m(valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .funct3_m(funct3_m), .alu_result_m(alu_result_m), .write_data_m(write_data_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .read_data_m(read_data_m), .stall_m(stall_m),
    .misaligned_m(misaligned_m), .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  // ack_delay: BUSY cycle (1-based) on which ack is pulsed; 0 means never.
  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          ack_delay;
    logic        exp_bad;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_berr;
    logic [31:0] exp_rd;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cur_rd = 32'd0;
  vec_t        tbl[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from the access rules, using plain arithmetic on sizes and offsets.
  function automatic vec_t model(input vec_t v, input logic [31:0] prev_rd);
    vec_t        r = v;
    int          size, off;
    logic [31:0] mask, x;
    case (v.f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    off = int'(v.addr % 4);
    r.exp_bad = (size == 0) || (v.rd && v.wr) || (v.wr && v.f3 >= 3'd4) ||
                (size != 0 && (v.addr % size) != 0);
    r.exp_berr = 1'b0;
    r.exp_rd   = prev_rd;
    r.exp_be   = 4'd0;
    r.exp_wdata = 32'd0;
    if (!r.exp_bad) begin
      mask = ((32'd1 << size) - 32'd1) << off;
      r.exp_be = mask[3:0];
      if (size == 1)      r.exp_wdata = (v.wd & 32'hFF) * 32'h0101_0101;
      else if (size == 2) r.exp_wdata = (v.wd & 32'hFFFF) * 32'h0001_0001;
      else                r.exp_wdata = v.wd;
      if (v.ack_delay == 0 || v.ack_delay > TIMEOUT) begin
        r.exp_berr = 1'b1;
        if (v.rd) r.exp_rd = 32'd0;
      end else if (v.rd) begin
        x = v.rdata >> (8 * off);
        if (size == 1) begin
          x = x & 32'hFF;
          if (v.f3 == 3'd0 && x >= 32'h80) x = x - 32'h100;
        end else if (size == 2) begin
          x = x & 32'hFFFF;
          if (v.f3 == 3'd1 && x >= 32'h8000) x = x - 32'h1_0000;
        end
        r.exp_rd = x;
      end
    end
    return r;
  endfunction

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_access(input vec_t v);
    bit done = 0;
    valid_m = 1'b1; mem_read_m = v.rd; mem_write_m = v.wr;
    funct3_m = v.f3; alu_result_m = v.addr; write_data_m = v.wd;
    #1;
    check("misaligned_m", misaligned_m, v.exp_bad);
    check("stall_idle", stall_m, !v.exp_bad);
    if (v.exp_bad) begin
      @(posedge clock); #1;
      valid_m = 1'b0;
      check("req_after_fault", dmem_req, 1'b0);
      check("rd_after_fault", read_data_m, v.exp_rd);
    end else begin
      @(posedge clock); #1;
      check("req_busy", dmem_req, 1'b1);
      check("dmem_addr", dmem_addr, {v.addr[31:2], 2'b00});
      check("dmem_be", dmem_be, v.exp_be);
      check("dmem_we", dmem_we, v.wr);
      if (v.wr) check("dmem_wdata", dmem_wdata, v.exp_wdata);
      valid_m = 1'($urandom); funct3_m = 3'($urandom);
      alu_result_m = $urandom; write_data_m = $urandom;
      for (int k = 1; k <= TIMEOUT && !done; k++) begin
        check("stall_busy", stall_m, 1'b1);
        if (k == v.ack_delay) begin
          dmem_ack = 1'b1; dmem_rdata = v.rdata;
        end
        @(posedge clock); #1;
        dmem_ack = 1'b0; dmem_rdata = $urandom;
        if (k == v.ack_delay || k == TIMEOUT) done = 1;
        else check("req_held", dmem_req, 1'b1);
      end
      check("stall_done", stall_m, 1'b0);
      check("req_done", dmem_req, 1'b0);
      check("bus_error", bus_error, v.exp_berr);
      check("read_data_m", read_data_m, v.exp_rd);
      @(posedge clock); #1;
      valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
      check("bus_error_pulse", bus_error, 1'b0);
    end
    cur_rd = v.exp_rd;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    reset = 1'b1; valid_m = 1'b0; mem_read_m = 1'b0; mem_write_m = 1'b0;
    funct3_m = 3'd0; alu_result_m = 32'd0; write_data_m = 32'd0;
    dmem_ack = 1'b0; dmem_rdata = 32'd0;

    //           rd wr f3      addr          wd            rdata         ack bad be     wdata         berr exp_rd
    tbl[0]  = '{1, 0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 2, 0, 4'hF, 32'h0,         0, 32'hDEADBEEF};
    tbl[1]  = '{1, 0, 3'b000, 32'h103, 32'h0,         32'h80FF0000, 1, 0, 4'h8, 32'h0,         0, 32'hFFFFFF80};
    tbl[2]  = '{1, 0, 3'b100, 32'h103, 32'h0,         32'h80FF0000, 1, 0, 4'h8, 32'h0,         0, 32'h00000080};
    tbl[3]  = '{0, 1, 3'b001, 32'h202, 32'h1234ABCD,  32'h0,        1, 0, 4'hC, 32'hABCDABCD,  0, 32'h00000080};
    tbl[4]  = '{1, 0, 3'b010, 32'h101, 32'h0,         32'h0,        1, 1, 4'h0, 32'h0,         0, 32'h00000080};
    tbl[5]  = '{1, 0, 3'b010, 32'h200, 32'h0,         32'h0,        0, 0, 4'hF, 32'h0,         1, 32'h00000000};
    tbl[6]  = '{1, 0, 3'b001, 32'h102, 32'h0,         32'h80017FFF, 4, 0, 4'hC, 32'h0,         0, 32'hFFFF8001};
    tbl[7]  = '{0, 1, 3'b000, 32'h001, 32'h000000A5,  32'h0,        3, 0, 4'h2, 32'hA5A5A5A5,  0, 32'hFFFF8001};
    tbl[8]  = '{0, 1, 3'b100, 32'h010, 32'h0,         32'h0,        1, 1, 4'h0, 32'h0,         0, 32'hFFFF8001};
    tbl[9]  = '{1, 1, 3'b010, 32'h020, 32'h0,         32'h0,        1, 1, 4'h0, 32'h0,         0, 32'hFFFF8001};
    tbl[10] = '{1, 0, 3'b011, 32'h030, 32'h0,         32'h0,        1, 1, 4'h0, 32'h0,         0, 32'hFFFF8001};
    tbl[11] = '{1, 0, 3'b101, 32'h002, 32'h0,         32'h80011234, 1, 0, 4'hC, 32'h0,         0, 32'h00008001};
    tbl[12] = '{0, 1, 3'b010, 32'h300, 32'hCAFEF00D,  32'h0,        2, 0, 4'hF, 32'hCAFEF00D,  0, 32'h00008001};
    tbl[13] = '{0, 1, 3'b010, 32'h304, 32'h11111111,  32'h0,        0, 0, 4'hF, 32'h11111111,  1, 32'h00008001};

    @(posedge clock); #1;
    check("reset_req", dmem_req, 1'b0);
    check("reset_rd", read_data_m, 32'd0);
    check("reset_berr", bus_error, 1'b0);
    check("reset_stall", stall_m, 1'b0);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 14; i++) run_access(tbl[i]);

    // Ack while idle must not disturb anything.
    dmem_ack = 1'b1; dmem_rdata = 32'h5555AAAA;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    check("idle_ack_req", dmem_req, 1'b0);
    check("idle_ack_rd", read_data_m, cur_rd);
    check("idle_ack_stall", stall_m, 1'b0);

    // Reset in the middle of BUSY, then a late ack.
    valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0;
    funct3_m = 3'b010; alu_result_m = 32'h400;
    @(posedge clock); #1;
    check("pre_reset_req", dmem_req, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("reset_busy_req", dmem_req, 1'b0);
    check("reset_busy_stall", stall_m, 1'b0);
    check("reset_busy_rd", read_data_m, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; valid_m = 1'b0; mem_read_m = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    @(posedge clock); #1;
    dmem_ack = 1'b0;
    check("late_ack_rd", read_data_m, 32'd0);
    check("late_ack_req", dmem_req, 1'b0);
    check("late_ack_berr", bus_error, 1'b0);
    check("late_ack_stall", stall_m, 1'b0);
    cur_rd = 32'd0;

    for (int i = 0; i < 200; i++) begin
      int sel = $urandom_range(0, 9);
      v.rd = (sel == 0) || (sel >= 5);
      v.wr = (sel <= 4);
      v.f3 = 3'($urandom_range(0, 7));
      v.addr = $urandom;
      if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
      v.wd = $urandom;
      v.rdata = $urandom;
      v.ack_delay = $urandom_range(0, TIMEOUT + 1);
      run_access(model(v, cur_rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-stage load/store unit of the 5-stage RISC-V core, downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result (the address), store data, Rd and access control.
- Drives a variable-latency data-memory bus with a req/ack handshake, stalls the pipeline while the access is outstanding, and returns aligned, sign/zero-extended load data toward the MEM/WB register.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles without dmem_ack before bus_error; range 1..255.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_m  in  1  instruction in MEM stage is valid
- mem_read_m  in  1  instruction is a load
- mem_write_m  in  1  instruction is a store; mem_read_m=mem_write_m=1 is illegal
- funct3_m  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- alu_result_m  in  32  byte address
- write_data_m  in  32  store data from rs2
- dmem_req  out  1  bus request, registered
- dmem_we  out  1  1=write, registered
- dmem_addr  out  32  word address {addr[31:2],2'b00}, registered
- dmem_be  out  4  byte enables, registered
- dmem_wdata  out  32  lane-replicated store data, registered
- dmem_ack  in  1  single-cycle completion from memory
- dmem_rdata  in  32  read word, valid when dmem_ack=1
- read_data_m  out  32  formatted load result, registered
- stall_m  out  1  freeze PC/IF/ID/EX and EX/MEM register
- misaligned_m  out  1  misaligned or illegal access, combinational
- bus_error  out  1  one-cycle pulse on timeout, registered

Behaviour:
- Reset values: all registered outputs 0, FSM in IDLE, timeout counter 0.
- access = valid_m & (mem_read_m | mem_write_m).
- bad = illegal funct3 (011, 110, 111; 100/101 with a store), or H/HU with addr[0]=1, or W with addr[1:0]≠0, or read & write both set.

FSM states: IDLE, BUSY, DONE.
- IDLE:
  - access & !bad: stall_m=1. Latch dmem_addr, dmem_be, dmem_wdata, dmem_we=mem_write_m, funct3 and addr[1:0]. Set dmem_req=1. Go to BUSY.
  - access & bad: misaligned_m=1, stall_m=0, no request, stay in IDLE.
  - Otherwise stall_m=0.
- BUSY:
  - stall_m=1, dmem_req held at 1, request fields stable, counter increments each cycle.
  - dmem_ack=1: dmem_req←0. For a load, read_data_m←formatted dmem_rdata. Go to DONE.
  - Counter reaches TIMEOUT without ack: dmem_req←0, bus_error←1 for one cycle, read_data_m←0 if load. Go to DONE.
- DONE: stall_m=0 so EX/MEM advances on this edge. Counter←0. Go to IDLE unconditionally; a new access is evaluated on the following cycle.
- Minimum access latency: 3 cycles (IDLE, BUSY with immediate ack, DONE).

Store formatting:
- SB: be=0001<<addr[1:0], wdata={4{wd[7:0]}}.
- SH: be=0011 if addr[1]=0 else 1100, wdata={2{wd[15:0]}}.
- SW: be=1111, wdata=wd.

Load formatting, lane selected by the latched addr[1:0]:
- LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Loads drive dmem_be like a store of the same size; dmem_wdata is don't-care.

Boundary conditions:
- read_data_m holds its value until the next load completes; stores and faults leave it unchanged.
- dmem_ack outside BUSY is ignored.
- Ack arriving on the same cycle the counter hits TIMEOUT: ack wins, no bus_error.
- Async reset mid-BUSY: dmem_req drops immediately, FSM goes to IDLE, a late ack is ignored.
- valid_m, funct3_m and address changes during BUSY are ignored; latched copies are used.

Test Plan:
- LW addr 0x100, ack after 2 BUSY cycles, rdata 0xDEADBEEF -> dmem_addr=0x100, be=1111, stall_m high 3 cycles, read_data_m=0xDEADBEEF in DONE.
- LB addr 0x103, rdata 0x80FF_0000 -> be=1000, read_data_m=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x202, wd 0x1234ABCD -> dmem_we=1, addr 0x200, be=1100, wdata=0xABCDABCD, read_data_m unchanged.
- LW addr 0x101 -> misaligned_m=1 same cycle, stall_m=0, dmem_req never asserted.
- TIMEOUT=4, no ack -> dmem_req high 4 cycles, bus_error pulses once, load read_data_m=0, FSM back to IDLE.
- Reset asserted during BUSY, then ack pulsed -> dmem_req=0 immediately, stall_m=0, read_data_m=0, no state change on ack.
